pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the single-level pipeline stall arbiter.
- Takes per-stage stall requests from an N-stage in-order pipeline and produces per-stage stall, bubble and flush controls.
- Adds a multi-cycle flush drain for jumps and saturating stall/flush performance counters.
- Adds a watchdog that flags a pipeline hang.
- Sits beside the pipeline registers; drives the hold/clear enables of every stage register.

Parameters:
- NUM_STAGES, 5, number of pipeline stages; index 0 = fetch, increasing toward writeback.
- FLUSH_EXTRA, 2, extra cycles flush[0] stays high after an accepted flush (drains in-flight fetches); 0 = single-cycle flush.
- CNT_W, 32, width of the performance counters.
- WDOG_LIMIT, 1024, consecutive stalled cycles before hang asserts; 0 disables the watchdog.
- SIDX_W, 3, width of the stage index; must satisfy 2^SIDX_W > NUM_STAGES.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset: synchronous, active-high.
- rdy, input, 1, global ready; low freezes the whole pipeline.
- stall_req, input, NUM_STAGES, bit i = stage i cannot complete this cycle.
- flush_req, input, 1, control-flow redirect resolved.
- flush_stage, input, SIDX_W, stage F that resolved the redirect; 1 <= F < NUM_STAGES.
- stall, output, NUM_STAGES, bit j = hold stage j register.
- bubble, output, NUM_STAGES, bit j = load NOP into stage j register.
- flush, output, NUM_STAGES, bit j = squash stage j contents.
- flush_ack, output, 1, flush_req accepted this cycle.
- stall_cycles, output, CNT_W, saturating count of cycles with any stall request while rdy.
- flush_count, output, CNT_W, saturating count of accepted flushes.
- hang, output, 1, sticky watchdog flag.

Behaviour:
- stall, bubble, flush and flush_ack are combinational from inputs and state. Counters, FSM and hang are registered.
- rst high: stall, bubble and flush = 0, flush_ack = 0. Next state: counters = 0, hang = 0, FSM = RUN, drain counter = 0.
- rdy low (rst low):
  - stall = all ones; bubble = 0; flush = 0; flush_ack = 0.
  - All registers hold, including FSM, drain counter, watchdog counter and perf counters.
  - A flush_req presented while rdy is low is not accepted.
- Stall resolution (rdy high): k = highest i with stall_req[i] = 1.
  - stall[j] = 1 for all j <= k.
  - bubble[k+1] = 1 if k+1 < NUM_STAGES.
  - No request: stall = 0, bubble = 0.
- Flush acceptance: flush_ack = flush_req & rdy & !(any stall_req[i] for i >= F).
  - If not accepted, the requester keeps flush_req high. This block does not latch it.
- On accept: flush[j] = 1 for j < F, and stall_req bits below F are ignored when computing k. Stages at or above F stall and bubble normally, i.e. k is taken over i >= F only, which is none by the acceptance rule.
- FSM RUN -> FLUSH on accept when FLUSH_EXTRA > 0; drain counter loads FLUSH_EXTRA.
- In FLUSH: flush[0] = 1 every rdy-high cycle. The counter decrements per rdy-high cycle. On the cycle it reads 1, the FSM returns to RUN next cycle.
- A new accept while in FLUSH reloads the counter to FLUSH_EXTRA and stays in FLUSH.
- In FLUSH, stall/bubble are still computed normally; flush[0] ORs in.
- stall_cycles: +1 on each rdy-high cycle with stall_req != 0; saturates at all ones.
- flush_count: +1 per flush_ack; saturates at all ones.
- Watchdog counter:
  - +1 each rdy-high cycle with stall_req != 0.
  - Cleared on any rdy-high cycle with stall_req == 0.
  - When it reaches WDOG_LIMIT, hang = 1 next cycle and stays 1 until rst.
  - The counter saturates at WDOG_LIMIT. With WDOG_LIMIT = 0, hang stays 0.
- rst mid-FLUSH: FSM to RUN, flush drops the same cycle rst is sampled high.

Test Plan:
- NUM_STAGES=5, stall_req=5'b01000 (stage 3) -> stall=5'b01111, bubble=5'b10000, flush=0; stall_cycles +1 per cycle.
- stall_req=5'b10010 -> stall=5'b11111, bubble=0 (k=4, no stage 5).
- flush_req=1, flush_stage=2, stall_req=5'b00001, FLUSH_EXTRA=2 -> that cycle flush=5'b00011, stall=0, flush_ack=1. Next two cycles: flush=5'b00001. Third cycle: flush=0. flush_count=1.
- flush_req=1, flush_stage=2, stall_req=5'b01000 -> flush_ack=0, flush=0, stall=5'b01111. After stall_req clears, the same request is acked.
- rdy=0 for 3 cycles mid-FLUSH with the drain counter at 2 -> stall=5'b11111, flush=0, counters frozen. After rdy=1, flush[0] is high for exactly 2 more cycles.
- WDOG_LIMIT=4, stall_req=5'b00100 held 4 cycles -> hang=1 on cycle 5 and stays 1 after stall_req clears. rst -> hang=0, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/flush generation, multi-cycle
// fetch flush drain, saturating stall/flush performance counters and a hang watchdog.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int FLUSH_EXTRA = 2,
    parameter int CNT_W       = 32,
    parameter int WDOG_LIMIT  = 1024,
    parameter int SIDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  flush_req,
    input  logic [SIDX_W-1:0]     flush_stage,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  flush_ack,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  hang
);

    localparam int DR_W = (FLUSH_EXTRA > 0) ? $clog2(FLUSH_EXTRA + 1) : 1;
    localparam int WD_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM  = WD_W'(WDOG_LIMIT);
    localparam logic [DR_W-1:0] DR_LOAD = DR_W'(FLUSH_EXTRA);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [DR_W-1:0]         drain_q, drain_d;
    logic [WD_W-1:0]         wdog_q, wdog_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic                    hang_q, hang_d;

    logic [NUM_STAGES-1:0]   ge_mask;
    logic [NUM_STAGES-1:0]   eff_req;
    logic [NUM_STAGES-1:0]   hold;
    logic                    hold_acc;
    logic                    accept;
    logic                    stall_any;

    always_comb begin
        ge_mask = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            ge_mask[i] = (SIDX_W'(i) >= flush_stage);
        end
    end

    assign stall_any = |stall_req;
    assign accept    = !rst && rdy && flush_req && !(|(stall_req & ge_mask));
    // Requests from stages being squashed do not hold anything back on an accept.
    assign eff_req   = accept ? (stall_req & ge_mask) : stall_req;

    // hold[j] = any effective request at stage j or above (stages 0..k stall).
    always_comb begin
        hold_acc = 1'b0;
        hold     = '0;
        for (int unsigned n = 0; n < NUM_STAGES; n++) begin
            hold_acc                  = hold_acc | eff_req[NUM_STAGES-1-n];
            hold[NUM_STAGES-1-n]      = hold_acc;
        end
    end

    always_comb begin
        stall     = '0;
        bubble    = '0;
        flush     = '0;
        flush_ack = 1'b0;
        if (!rst) begin
            if (!rdy) begin
                stall = '1;
            end else begin
                stall     = hold;
                bubble    = (hold << 1) & ~hold;
                flush_ack = accept;
                if (accept) begin
                    flush = ~ge_mask;
                end
                if (state_q == S_FLUSH) begin
                    flush[0] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (rdy) begin
            if (accept && (FLUSH_EXTRA > 0)) begin
                state_d = S_FLUSH;
                drain_d = DR_LOAD;
            end else if (state_q == S_FLUSH) begin
                if (drain_q <= DR_W'(1)) begin
                    state_d = S_RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DR_W'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wdog_d      = wdog_q;
        hang_d      = hang_q;
        if (rdy) begin
            if (stall_any && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (accept && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (!stall_any) begin
                wdog_d = '0;
            end else if (wdog_q != WD_LIM) begin
                wdog_d = wdog_q + WD_W'(1);
            end
            if ((WDOG_LIMIT > 0) && (wdog_d == WD_LIM)) begin
                hang_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            drain_q     <= '0;
            wdog_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            hang_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            wdog_q      <= wdog_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hang_q      <= hang_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign hang         = hang_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus hand-written
// sequences for flush drain, rdy freeze, watchdog, reset and counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [4:0] stall_req;
    logic       flush_req;
    logic [2:0] flush_stage;
    logic [4:0] stall, bubble, flush;
    logic       flush_ack;
    logic [3:0] stall_cycles, flush_count;
    logic       hang;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(
        .NUM_STAGES (5),
        .FLUSH_EXTRA(2),
        .CNT_W      (4),
        .WDOG_LIMIT (4),
        .SIDX_W     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .flush_stage (flush_stage),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .flush_ack   (flush_ack),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count),
        .hang        (hang)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic [4:0] sr;
        logic       fr;
        logic [2:0] fs;
        logic [4:0] e_stall;
        logic [4:0] e_bub;
        logic [4:0] e_flush;
        logic       e_ack;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [4:0] sr, input logic fr, input logic [2:0] fs);
        rdy         = r;
        stall_req   = sr;
        flush_req   = fr;
        flush_stage = fs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'b01000, 1'b0, 3'd0, 5'b01111, 5'b10000, 5'b00000, 1'b0};
        tbl[1]  = '{1'b1, 5'b10010, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 1'b0};
        tbl[2]  = '{1'b1, 5'b00000, 1'b0, 3'd0, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        tbl[3]  = '{1'b1, 5'b00001, 1'b0, 3'd0, 5'b00001, 5'b00010, 5'b00000, 1'b0};
        tbl[4]  = '{1'b0, 5'b00100, 1'b1, 3'd2, 5'b11111, 5'b00000, 5'b00000, 1'b0};
        tbl[5]  = '{1'b1, 5'b00001, 1'b1, 3'd2, 5'b00000, 5'b00000, 5'b00011, 1'b1};
        tbl[6]  = '{1'b1, 5'b01000, 1'b1, 3'd2, 5'b01111, 5'b10000, 5'b00000, 1'b0};
        tbl[7]  = '{1'b1, 5'b00010, 1'b1, 3'd4, 5'b00000, 5'b00000, 5'b01111, 1'b1};
        tbl[8]  = '{1'b1, 5'b10000, 1'b1, 3'd4, 5'b11111, 5'b00000, 5'b00000, 1'b0};
        tbl[9]  = '{1'b1, 5'b00100, 1'b1, 3'd1, 5'b00111, 5'b01000, 5'b00000, 1'b0};
        tbl[10] = '{1'b1, 5'b00000, 1'b1, 3'd1, 5'b00000, 5'b00000, 5'b00001, 1'b1};
        tbl[11] = '{1'b1, 5'b00011, 1'b1, 3'd3, 5'b00000, 5'b00000, 5'b00111, 1'b1};

        // Outputs forced low while rst is sampled, even with active requests.
        rst = 1'b1;
        drive(1'b1, 5'b01000, 1'b1, 3'd2);
        #1;
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst bubble", 32'(bubble), 32'h0);
        chk("rst flush", 32'(flush), 32'h0);
        chk("rst ack", 32'(flush_ack), 32'h0);
        do_reset();
        chk("post-rst stall_cycles", 32'(stall_cycles), 32'h0);
        chk("post-rst flush_count", 32'(flush_count), 32'h0);
        chk("post-rst hang", 32'(hang), 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rdy, tbl[i].sr, tbl[i].fr, tbl[i].fs);
            #1;
            chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d bubble", i), 32'(bubble), 32'(tbl[i].e_bub));
            chk($sformatf("row%0d flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("row%0d ack", i), 32'(flush_ack), 32'(tbl[i].e_ack));
            tick();
            drive(1'b1, 5'b0, 1'b0, 3'd0);
            repeat (3) tick();
        end

        // Flush drain: accept cycle, then two cycles of flush[0].
        do_reset();
        drive(1'b1, 5'b00001, 1'b1, 3'd2);
        #1;
        chk("drain accept flush", 32'(flush), 32'h03);
        chk("drain accept stall", 32'(stall), 32'h0);
        chk("drain accept ack", 32'(flush_ack), 32'h1);
        tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        #1;
        chk("drain c1 flush", 32'(flush), 32'h01);
        tick();
        chk("drain c2 flush", 32'(flush), 32'h01);
        tick();
        chk("drain c3 flush", 32'(flush), 32'h00);
        chk("drain flush_count", 32'(flush_count), 32'h1);
        chk("drain stall_cycles", 32'(stall_cycles), 32'h1);

        // Blocked request is acked once the stall below it clears.
        drive(1'b1, 5'b01000, 1'b1, 3'd2);
        #1;
        chk("blocked ack", 32'(flush_ack), 32'h0);
        chk("blocked flush", 32'(flush), 32'h0);
        chk("blocked stall", 32'(stall), 32'h0f);
        tick();
        drive(1'b1, 5'b0, 1'b1, 3'd2);
        #1;
        chk("unblocked ack", 32'(flush_ack), 32'h1);
        chk("unblocked flush", 32'(flush), 32'h03);
        tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        repeat (3) tick();
        chk("blocked flush_count", 32'(flush_count), 32'h2);
        chk("blocked stall_cycles", 32'(stall_cycles), 32'h2);

        // rdy low mid-drain freezes everything; drain resumes afterwards.
        do_reset();
        drive(1'b1, 5'b0, 1'b1, 3'd2);
        tick();
        drive(1'b0, 5'b00100, 1'b1, 3'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("frz%0d stall", c), 32'(stall), 32'h1f);
            chk($sformatf("frz%0d flush", c), 32'(flush), 32'h0);
            chk($sformatf("frz%0d ack", c), 32'(flush_ack), 32'h0);
            tick();
        end
        chk("frz stall_cycles", 32'(stall_cycles), 32'h0);
        chk("frz flush_count", 32'(flush_count), 32'h1);
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        #1;
        chk("resume c1 flush", 32'(flush), 32'h01);
        tick();
        chk("resume c2 flush", 32'(flush), 32'h01);
        tick();
        chk("resume c3 flush", 32'(flush), 32'h00);

        // Re-accept while draining reloads the drain counter.
        drive(1'b1, 5'b0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 5'b0, 1'b1, 3'd3);
        #1;
        chk("reacc flush", 32'(flush), 32'h07);
        chk("reacc ack", 32'(flush_ack), 32'h1);
        tick();
        drive(1'b1, 5'b01000, 1'b0, 3'd0);
        #1;
        chk("reacc c1 flush", 32'(flush), 32'h01);
        chk("reacc c1 stall", 32'(stall), 32'h0f);
        chk("reacc c1 bubble", 32'(bubble), 32'h10);
        tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        #1;
        chk("reacc c2 flush", 32'(flush), 32'h01);
        tick();
        chk("reacc c3 flush", 32'(flush), 32'h00);

        // Watchdog: clears on an idle cycle, fires after 4 consecutive stalls.
        do_reset();
        drive(1'b1, 5'b00100, 1'b0, 3'd0);
        repeat (3) tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        tick();
        drive(1'b1, 5'b00100, 1'b0, 3'd0);
        repeat (3) tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        tick();
        chk("wdog cleared hang", 32'(hang), 32'h0);
        drive(1'b1, 5'b00100, 1'b0, 3'd0);
        repeat (3) tick();
        chk("wdog c4 hang", 32'(hang), 32'h0);
        tick();
        chk("wdog c5 hang", 32'(hang), 32'h1);
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        repeat (2) tick();
        chk("wdog sticky hang", 32'(hang), 32'h1);
        chk("wdog stall_cycles", 32'(stall_cycles), 32'd10);
        do_reset();
        chk("wdog rst hang", 32'(hang), 32'h0);
        chk("wdog rst stall_cycles", 32'(stall_cycles), 32'h0);

        // Reset mid-drain drops flush immediately and returns to RUN.
        drive(1'b1, 5'b0, 1'b1, 3'd2);
        tick();
        drive(1'b1, 5'b0, 1'b0, 3'd0);
        rst = 1'b1;
        #1;
        chk("rst-mid flush", 32'(flush), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst-mid after flush", 32'(flush), 32'h0);
        chk("rst-mid flush_count", 32'(flush_count), 32'h0);

        // Saturation of both 4-bit counters.
        drive(1'b1, 5'b00010, 1'b0, 3'd0);
        repeat (20) tick();
        chk("sat stall_cycles", 32'(stall_cycles), 32'hf);
        drive(1'b1, 5'b0, 1'b1, 3'd1);
        repeat (17) tick();
        chk("sat flush_count", 32'(flush_count), 32'hf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
